serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around a single one-bit full-adder slice and a carry flip-flop. It accepts two parallel operands plus carry-in on a start pulse and adds them LSB-first, one bit per clock. It returns the registered parallel sum and carry-out with a one-cycle done strobe. It sits directly downstream of the combinational full adder, reusing its Sum/Cout equations as the per-bit datapath.

## Interface

- WIDTH, 8, operand and sum width in bits (legal range 2..32)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle strobe; sum/cout valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held with sum

## Operation

- States: IDLE, RUN, DONE (registered FSM).
- IDLE:
  - start=1 → load shift regs a_sr←a, b_sr←b, carry←cin, bit counter←0, go RUN.
  - start=0 → stay.
- RUN, each cycle:
  - s = a_sr[0]^b_sr[0]^carry; c = majority(a_sr[0], b_sr[0], carry).
  - a_sr, b_sr shift right by 1.
  - s shifts into MSB of internal sum_sr; carry←c; counter++.
  - When counter == WIDTH-1 (last bit) → sum←final sum_sr contents including this bit, cout←c, go DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → behaves as IDLE accept (back-to-back op), go RUN.
  - start=0 → go IDLE.
- start in RUN is ignored; no queueing. a, b, cin are don't-care except at an accepted start edge.
- sum/cout update only at the DONE transition; they never show partial results, and they hold their value through IDLE and during the next RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH) bits minimum; wrap is not reachable.

## Timing

- Reset (rst_n=0 at a rising edge):
  - FSM→IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift regs, carry and counter cleared.
- Reset wins over start on the same edge.
- Reset mid-RUN aborts the operation; the held sum/cout are cleared to 0.
- Latency: start accepted at edge E0.
  - busy=1 after E0 through edge E_WIDTH.
  - After E_WIDTH: done=1, busy=0, sum/cout valid.
  - After E_WIDTH+1: done=0, unless restarted.
- Throughput:
  - back-to-back: one result per WIDTH+1 cycles (start held high in DONE).
  - single op returning to IDLE: WIDTH+2 cycles per result.
- busy and done are never high together. All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset then idle, WIDTH=8: hold rst_n=0 for 2 cycles → busy=0, done=0, sum=0x00, cout=0; start=0 for 5 cycles → no change.
- Full carry ripple: a=0xFF, b=0x01, cin=0 → done 8 cycles after accept edge, sum=0x00, cout=1; sum unchanged while busy.
- Carry-in propagation: a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1; then a=0x12, b=0x34, cin=0 → sum=0x46, cout=0.
- Start during RUN: second start with a=0x0F, b=0x0F pulsed at cycle 3 of an op on a=0x01, b=0x02, cin=0 → ignored; result sum=0x03, cout=0; exactly one done pulse.
- Back-to-back: start held high continuously, operands 0x80+0x80 then 0x7F+0x01 → done pulses 9 cycles apart; results {1,0x00} then {0,0x80}.
- Reset mid-op: rst_n=0 at RUN cycle 4 → next cycle busy=0, done=0, sum=0, cout=0; a fresh op afterwards computes 0x55+0xAA+1 → sum=0x00, cout=1.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives start
// and operands, the adder returns status and the registered result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB
// first, one bit per clock. {cout,sum} = a + b + cin, published with a
// one-cycle done strobe and held until the next completion.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               accept;
    logic               last_bit;
    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   sum_shift;

    // State and datapath registers; reset also clears the published result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state: start is honoured only in IDLE or DONE, ignored in RUN.
    always_comb begin
        accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
        state_d  = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: full-adder slice on the LSBs, shift everything right by one.
    always_comb begin
        fa_s      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_c      = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
        sum_shift = {fa_s, sum_sr_q[WIDTH-1:1]};
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        if (accept) begin
            a_sr_d   = bus.a;
            b_sr_d   = bus.b;
            sum_sr_d = '0;
            carry_d  = bus.cin;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_shift;
            carry_d  = fa_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
                sum_d  = sum_shift;
                cout_d = fa_c;
            end
        end
    end

    // Outputs: all decoded from flops, no path from the request inputs.
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: expected {cout,sum} pushed at launch,
// popped and compared when done strobes.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   tests    = 0;
    int   failed   = 0;
    int   cyc_cnt  = 0;
    int   done_cnt = 0;
    logic [WIDTH:0] sb[$];
    logic [WIDTH:0] held_res;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) sa_if ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sa_if)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // done pulse tally and busy/done exclusivity
    always @(negedge clk) begin
        if (sa_if.done === 1'b1) done_cnt <= done_cnt + 1;
        if (rst_n === 1'b1 && (sa_if.busy === 1'b1 || sa_if.done === 1'b1))
            check("busy_done_excl", {31'b0, sa_if.busy & sa_if.done}, 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH:0] e;
        sa_if.a   = a;
        sa_if.b   = b;
        sa_if.cin = cin;
        e = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
        sb.push_back(e);
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit hold, output int acc);
        set_ops(a, b, cin);
        sa_if.start = 1'b1;
        cyc();
        acc = cyc_cnt;
        if (!hold) sa_if.start = 1'b0;
    endtask

    task automatic wait_done(input int acc, input string tag, output int at);
        logic [WIDTH:0] e;
        int n = 0;
        while (n < 4 * WIDTH) begin
            cyc();
            n++;
            if (sa_if.done === 1'b1) break;
            check({tag, "_sum_hold"}, 32'(sa_if.sum), 32'(held_res[WIDTH-1:0]));
            check({tag, "_cout_hold"}, 32'(sa_if.cout), 32'(held_res[WIDTH]));
        end
        at = cyc_cnt;
        check({tag, "_done"}, 32'(sa_if.done), 32'd1);
        check({tag, "_latency"}, 32'(at - acc), 32'(WIDTH));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(sa_if.sum), 32'(e[WIDTH-1:0]));
            check({tag, "_cout"}, 32'(sa_if.cout), 32'(e[WIDTH]));
            held_res = e;
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_busy"}, 32'(sa_if.busy), 32'd0);
        check({tag, "_done"}, 32'(sa_if.done), 32'd0);
        check({tag, "_sum"},  32'(sa_if.sum),  32'(held_res[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(sa_if.cout), 32'(held_res[WIDTH]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, d0, d1, d2, base;
        rst_n       = 1'b0;
        sa_if.start = 1'b0;
        sa_if.a     = '0;
        sa_if.b     = '0;
        sa_if.cin   = 1'b0;
        held_res    = '0;

        // reset, then idle with start low
        cyc();
        cyc();
        idle_check("reset");
        rst_n = 1'b1;
        repeat (5) begin
            cyc();
            idle_check("idle");
        end

        // full carry ripple
        launch(8'hFF, 8'h01, 1'b0, 1'b0, acc);
        check("ripple_busy", 32'(sa_if.busy), 32'd1);
        wait_done(acc, "ripple", d0);
        cyc();
        idle_check("ripple_after");

        // carry-in propagation then ordinary add
        launch(8'hA5, 8'h5A, 1'b1, 1'b0, acc);
        wait_done(acc, "cin", d0);
        cyc();
        launch(8'h12, 8'h34, 1'b0, 1'b0, acc);
        wait_done(acc, "plain", d0);
        cyc();
        idle_check("plain_after");

        // start during RUN must be ignored
        launch(8'h01, 8'h02, 1'b0, 1'b0, acc);
        base = done_cnt;
        cyc();
        cyc();
        sa_if.a     = 8'h0F;
        sa_if.b     = 8'h0F;
        sa_if.start = 1'b1;
        cyc();
        sa_if.start = 1'b0;
        wait_done(acc, "midstart", d0);
        repeat (3) cyc();
        check("midstart_pulses", 32'(done_cnt - base), 32'd1);
        idle_check("midstart_after");

        // back-to-back with start held high
        launch(8'h80, 8'h80, 1'b0, 1'b1, acc);
        set_ops(8'h7F, 8'h01, 1'b0);
        wait_done(acc, "b2b0", d1);
        cyc();
        acc = cyc_cnt;
        sa_if.start = 1'b0;
        check("b2b_restart_busy", 32'(sa_if.busy), 32'd1);
        wait_done(acc, "b2b1", d2);
        check("b2b_spacing", 32'(d2 - d1), 32'(WIDTH + 1));
        cyc();
        idle_check("b2b_after");

        // reset mid-operation clears held result
        launch(8'hF0, 8'h0F, 1'b0, 1'b0, acc);
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        sb.delete();
        held_res = '0;
        idle_check("midreset");
        rst_n = 1'b1;
        cyc();
        idle_check("postreset");
        launch(8'h55, 8'hAA, 1'b1, 1'b0, acc);
        wait_done(acc, "fresh", d0);
        cyc();
        idle_check("fresh_after");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
